// File: rtl/sweep_pkg.sv
// Shared types and constants for the truth-table sweeper.
// The MISR constants are used only when SWEEP_MISR_EN is defined.
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  function automatic int cnt_width(input int settle);
    return (settle < 1) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/sweep_misr.sv
// 16-bit Galois MISR, x^16+x^12+x^5+1, for the sweep signature.
// Instantiated by truth_table_sweeper only under SWEEP_MISR_EN.
module sweep_misr
  import sweep_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        shift,
  input  logic [15:0] din,
  output logic [15:0] sig
);

  logic [15:0] fb;

  assign fb = sig[15] ? MISR_POLY : 16'h0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= 16'h0000;
    end else if (init) begin
      sig <= MISR_SEED;
    end else if (shift) begin
      sig <= {sig[14:0], 1'b0} ^ fb ^ din;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive input sweep and truth-table capture for a combinational unit.
// Define SWEEP_MISR_EN to add a MISR signature over the sampled outputs.
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 2,
  parameter int SETTLE = 1
) (
  input  logic                      Clock,
  input  logic                      Reset_b,
  input  logic                      Start,
  input  logic                      Abort,
  output logic [N_IN-1:0]           Vec,
  input  logic [N_OUT-1:0]          F,
  input  logic [N_OUT*(1<<N_IN)-1:0] Exp_Table,
  output logic [N_OUT*(1<<N_IN)-1:0] Result,
  output logic                      Busy,
  output logic                      Done,
  output logic [N_IN:0]             Err_Count,
  output logic [15:0]               Signature
);

  localparam int NV = 1 << N_IN;
  localparam int TW = N_OUT * NV;
  localparam int IW = $clog2(TW);
  localparam int CW = cnt_width(SETTLE);
  localparam logic [N_IN-1:0] VMAX = '1;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [TW-1:0]   res_nxt;
  logic            hit_err;
  logic [IW-1:0]   idx;

  // Merge this vector's F bits into the table and flag any mismatch
  always_comb begin
    res_nxt = Result;
    hit_err = 1'b0;
    idx     = '0;
    for (int k = 0; k < N_OUT; k++) begin
      idx = IW'(k * NV) + IW'(Vec);
      res_nxt[idx] = F[k];
      if (F[k] != Exp_Table[idx]) hit_err = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      state     <= IDLE;
      cnt       <= '0;
      Vec       <= '0;
      Result    <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Err_Count <= '0;
    end else if (Abort) begin
      state <= IDLE;
      Vec   <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            state     <= WAIT;
            Result    <= '0;
            Err_Count <= '0;
            Vec       <= '0;
            cnt       <= CW'(SETTLE);
            Busy      <= 1'b1;
            Done      <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else           state <= SAMPLE;
        end
        SAMPLE: begin
          Result <= res_nxt;
          if (hit_err) Err_Count <= Err_Count + 1'b1;
          if (Vec == VMAX) begin
            state <= DONE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end else begin
            state <= WAIT;
            Vec   <= Vec + 1'b1;
            cnt   <= CW'(SETTLE);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SWEEP_MISR_EN
  logic start_go;
  logic do_sample;

  assign start_go  = !Abort && Start &&
                     (state == IDLE || state == DONE);
  assign do_sample = !Abort && (state == SAMPLE);

  sweep_misr u_misr (
    .clk   (Clock),
    .rst_n (Reset_b),
    .init  (start_go),
    .shift (do_sample),
    .din   (16'(F)),
    .sig   (Signature)
  );
`else
  assign Signature = 16'h0000;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: SETTLE=1 and SETTLE=0 instances.
module tb_truth_table_sweeper;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  err;
    logic [15:0] sig;
    int          cycles;
  } exp_t;

  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start1, abort1, start0, abort0;
  logic [3:0]  vec1, vec0;
  logic [1:0]  f1, f0;
  logic [31:0] exp1, exp0, res1, res0;
  logic        busy1, busy0, done1, done0;
  logic [4:0]  err1, err0;
  logic [15:0] sig1, sig0;

  function automatic logic [1:0] ref_f(input logic [3:0] v);
    logic [15:0] fa;
    logic [15:0] fb;
    fa = 16'hF81A;
    fb = 16'hADA6;
    return {fa[v], fb[v]};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s,
                                            input logic [1:0] f);
    logic [15:0] n;
    n = {s[14:0], 1'b0};
    if (s[15]) n = n ^ 16'h1021;
    return n ^ {14'b0, f};
  endfunction

  function automatic exp_t model(input logic [31:0] tbl,
                                 input int nvec, input int cyc);
    exp_t e;
    logic [1:0] f;
    e.res = '0;
    e.err = '0;
    e.cycles = cyc;
`ifdef SWEEP_MISR_EN
    e.sig = 16'hFFFF;
`else
    e.sig = 16'h0000;
`endif
    for (int v = 0; v < nvec; v++) begin
      f = ref_f(4'(v));
      e.res[16+v] = f[1];
      e.res[v]    = f[0];
      if (f[1] != tbl[16+v] || f[0] != tbl[v]) e.err = e.err + 5'd1;
`ifdef SWEEP_MISR_EN
      e.sig = misr_step(e.sig, f);
`endif
    end
    return e;
  endfunction

  assign f1 = ref_f(vec1);
  assign f0 = ref_f(vec0);

  truth_table_sweeper #(.N_IN(4), .N_OUT(2), .SETTLE(1)) dut1 (
    .Clock     (clk),
    .Reset_b   (rst_n),
    .Start     (start1),
    .Abort     (abort1),
    .Vec       (vec1),
    .F         (f1),
    .Exp_Table (exp1),
    .Result    (res1),
    .Busy      (busy1),
    .Done      (done1),
    .Err_Count (err1),
    .Signature (sig1)
  );

  truth_table_sweeper #(.N_IN(4), .N_OUT(2), .SETTLE(0)) dut0 (
    .Clock     (clk),
    .Reset_b   (rst_n),
    .Start     (start0),
    .Abort     (abort0),
    .Vec       (vec0),
    .F         (f0),
    .Exp_Table (exp0),
    .Result    (res0),
    .Busy      (busy0),
    .Done      (done0),
    .Err_Count (err0),
    .Signature (sig0)
  );

  task automatic pulse_start(input bit sel);
    @(negedge clk);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start0 = 1'b0;
  endtask

  task automatic run_to_done(input bit sel, output int cyc,
                             output logic [31:0] r, output logic [4:0] e,
                             output logic [15:0] s, output bit to);
    cyc = 0;
    to  = 1'b1;
    while (cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
      if (sel ? done1 : done0) begin
        to = 1'b0;
        break;
      end
    end
    r = sel ? res1 : res0;
    e = sel ? err1 : err0;
    s = sel ? sig1 : sig0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start1 = 1'b0; abort1 = 1'b0; start0 = 1'b0; abort0 = 1'b0;
    exp1 = 32'hF81AADA6;
    exp0 = 32'hF81AADA6;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (vec1 !== 4'd0 || res1 !== 32'd0) begin
      fails++;
      $display("FAIL reset_vec_res: vec=%0d res=%h, want 0/0", vec1, res1);
    end
    tests++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      fails++;
      $display("FAIL reset_busy_done: busy=%b done=%b, want 0/0",
               busy1, done1);
    end
    tests++;
    if (err1 !== 5'd0 || sig1 !== 16'd0) begin
      fails++;
      $display("FAIL reset_err_sig: err=%0d sig=%h, want 0/0", err1, sig1);
    end
  endtask

  task automatic test_sweep(input logic [31:0] tbl, input string nm);
    int cyc; logic [31:0] r; logic [4:0] e; logic [15:0] s; bit to;
    exp_t x;
    exp1 = tbl;
    sb.push_back(model(tbl, 16, 48));
    pulse_start(1'b1);
    tests++;
    if (busy1 !== 1'b1) begin
      fails++;
      $display("FAIL %s_busy: busy=%b, want 1", nm, busy1);
    end
    run_to_done(1'b1, cyc, r, e, s, to);
    x = sb.pop_front();
    tests++;
    if (to || cyc != x.cycles) begin
      fails++;
      $display("FAIL %s_cycles: got %0d (timeout=%0b), want %0d",
               nm, cyc, to, x.cycles);
    end
    tests++;
    if (r !== x.res || e !== x.err) begin
      fails++;
      $display("FAIL %s_table: res=%h err=%0d, want res=%h err=%0d",
               nm, r, e, x.res, x.err);
    end
    tests++;
    if (s !== x.sig || busy1 !== 1'b0) begin
      fails++;
      $display("FAIL %s_sig: sig=%h busy=%b, want sig=%h busy=0",
               nm, s, busy1, x.sig);
    end
  endtask

  task automatic test_abort;
    exp_t x;
    exp1 = 32'hF81AADA6;
    x = model(exp1, 6, 0);
    sb.push_back(x);
    pulse_start(1'b1);
    repeat (19) @(posedge clk);
    #1;
    abort1 = 1'b1;
    @(posedge clk);
    #1;
    abort1 = 1'b0;
    x = sb.pop_front();
    tests++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || vec1 !== 4'd0) begin
      fails++;
      $display("FAIL abort_state: busy=%b done=%b vec=%0d, want 0/0/0",
               busy1, done1, vec1);
    end
    tests++;
    if (res1 !== x.res || err1 !== x.err) begin
      fails++;
      $display("FAIL abort_partial: res=%h err=%0d, want res=%h err=%0d",
               res1, err1, x.res, x.err);
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || res1 !== x.res) begin
      fails++;
      $display("FAIL abort_idle: busy=%b done=%b res=%h, want 0/0/%h",
               busy1, done1, res1, x.res);
    end
  endtask

  task automatic test_settle0;
    int cyc; logic [31:0] r; logic [4:0] e; logic [15:0] s; bit to;
    exp_t x;
    for (int pass = 0; pass < 2; pass++) begin
      sb.push_back(model(exp0, 16, 32));
      pulse_start(1'b0);
      if (pass == 1) begin
        tests++;
        if (res0 !== 32'd0 || done0 !== 1'b0 || err0 !== 5'd0) begin
          fails++;
          $display("FAIL restart_clear: res=%h done=%b err=%0d, want 0/0/0",
                   res0, done0, err0);
        end
      end
      run_to_done(1'b0, cyc, r, e, s, to);
      x = sb.pop_front();
      tests++;
      if (to || cyc != x.cycles || r !== x.res || s !== x.sig) begin
        fails++;
        $display("FAIL settle0_p%0d: cyc=%0d res=%h sig=%h, want %0d/%h/%h",
                 pass, cyc, r, s, x.cycles, x.res, x.sig);
      end
    end
  endtask

  task automatic test_start_busy;
    int cyc;
    exp_t x;
    bit to;
    sb.push_back(model(exp0, 16, 32));
    pulse_start(1'b0);
    cyc = 0;
    to = 1'b1;
    while (cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
      start0 = (cyc == 9);
      if (done0) begin
        to = 1'b0;
        break;
      end
    end
    start0 = 1'b0;
    x = sb.pop_front();
    tests++;
    if (to || cyc != x.cycles || res0 !== x.res || err0 !== x.err) begin
      fails++;
      $display("FAIL start_busy: cyc=%0d res=%h err=%0d, want %0d/%h/%0d",
               cyc, res0, err0, x.cycles, x.res, x.err);
    end
  endtask

  task automatic test_async_reset;
    exp1 = 32'hF81AADA6;
    pulse_start(1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (res1 !== 32'd0 || vec1 !== 4'd0 || busy1 !== 1'b0 ||
        done1 !== 1'b0 || err1 !== 5'd0 || sig1 !== 16'd0) begin
      fails++;
      $display("FAIL async_reset: res=%h vec=%0d busy=%b done=%b err=%0d sig=%h",
               res1, vec1, busy1, done1, err1, sig1);
    end
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || vec1 !== 4'd0) begin
      fails++;
      $display("FAIL post_reset_idle: busy=%b done=%b vec=%0d, want 0/0/0",
               busy1, done1, vec1);
    end
  endtask

  initial begin
    test_reset();
    test_sweep(32'hF81AADA6, "ref");
    test_sweep(32'hF81AADA7, "err1");
    test_sweep(~32'hF81AADA6, "errall");
    test_abort();
    test_settle0();
    test_start_busy();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
